// File: rtl/riscv_regfile_sb.sv
// ============================================================================
// Module      : riscv_regfile_sb
// Description : Multi-port RISC-V integer register file with a per-register
//               pending-write scoreboard. Optional write-through forwarding is
//               enabled by defining the macro REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int PEND_W = 2,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [NREAD*AW-1:0]   ra_in,
   output logic [NREAD*XLEN-1:0] rdata_out,
   output logic [NREAD-1:0]      hazard_out,
   input  logic                  wr_en_in,
   input  logic [AW-1:0]         wr_addr_in,
   input  logic [XLEN-1:0]       wr_data_in,
   input  logic                  rsv_en_in,
   input  logic [AW-1:0]         rsv_addr_in,
   output logic                  rsv_ready_out,
   output logic                  err_out
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic [XLEN-1:0]   regs_q [NREGS];
   logic [XLEN-1:0]   regs_d [NREGS];
   logic [PEND_W-1:0] cnt_q  [NREGS];
   logic [PEND_W-1:0] cnt_d  [NREGS];
   logic              err_q;
   logic              err_d;

   logic              rsv_acc;
   logic              rel;
   logic              same_addr;

   assign rel           = wr_en_in && (wr_addr_in != '0);
   assign rsv_acc       = rsv_en_in && (rsv_addr_in != '0) && (cnt_q[rsv_addr_in] != CNT_MAX);
   assign same_addr     = (wr_addr_in == rsv_addr_in);
   assign rsv_ready_out = rst_in || (rsv_addr_in == '0) || (cnt_q[rsv_addr_in] != CNT_MAX);
   assign err_out       = err_q;

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (rel) begin
         regs_d[wr_addr_in] = wr_data_in;
         if (cnt_q[wr_addr_in] == '0) begin
            err_d = 1'b1;
         end
      end
      // A reservation and a release on the same register cancel out.
      if (rsv_acc && !(rel && same_addr)) begin
         cnt_d[rsv_addr_in] = cnt_q[rsv_addr_in] + CNT_ONE;
      end
      if (rel && (cnt_q[wr_addr_in] != '0) && !(rsv_acc && same_addr)) begin
         cnt_d[wr_addr_in] = cnt_q[wr_addr_in] - CNT_ONE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_read
      logic [AW-1:0] addr;
      assign addr = ra_in[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic wr_hit;
      assign wr_hit = wr_en_in && (wr_addr_in == addr);
      assign rdata_out[i*XLEN +: XLEN] = (rst_in || (addr == '0)) ? '0 :
                                         wr_hit ? wr_data_in : regs_q[addr];
      // The last outstanding write landing this cycle resolves the hazard.
      assign hazard_out[i] = !rst_in && (addr != '0) && (cnt_q[addr] != '0) &&
                             !(wr_hit && (cnt_q[addr] == CNT_ONE));
`else
      assign rdata_out[i*XLEN +: XLEN] = (rst_in || (addr == '0)) ? '0 : regs_q[addr];
      assign hazard_out[i] = !rst_in && (addr != '0) && (cnt_q[addr] != '0);
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_riscv_regfile_sb.sv
// ============================================================================
// Module      : tb_riscv_regfile_sb
// Description : Self-checking bench for riscv_regfile_sb against an array-based
//               reference model; honours REGFILE_BYPASS_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_riscv_regfile_sb;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NREAD  = 2;
   localparam int PEND_W = 2;
   localparam int AW     = 5;
   localparam int MAXC   = (1 << PEND_W) - 1;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic [NREAD*AW-1:0]   ra_in;
   logic [NREAD*XLEN-1:0] rdata_out;
   logic [NREAD-1:0]      hazard_out;
   logic                  wr_en_in;
   logic [AW-1:0]         wr_addr_in;
   logic [XLEN-1:0]       wr_data_in;
   logic                  rsv_en_in;
   logic [AW-1:0]         rsv_addr_in;
   logic                  rsv_ready_out;
   logic                  err_out;

   riscv_regfile_sb #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NREAD  (NREAD),
      .PEND_W (PEND_W)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .ra_in         (ra_in),
      .rdata_out     (rdata_out),
      .hazard_out    (hazard_out),
      .wr_en_in      (wr_en_in),
      .wr_addr_in    (wr_addr_in),
      .wr_data_in    (wr_data_in),
      .rsv_en_in     (rsv_en_in),
      .rsv_addr_in   (rsv_addr_in),
      .rsv_ready_out (rsv_ready_out),
      .err_out       (err_out)
   );

   always #5 clk_in = ~clk_in;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_reg [NREGS];
   int          m_cnt [NREGS];
   bit          m_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_reg[r] = '0;
         m_cnt[r] = 0;
      end
      m_err = 1'b0;
   endtask

   // One clock cycle: drive, compare against the model at mid-cycle, advance model.
   task automatic cyc(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                      input bit re, input int rsa, input int a0, input int a1);
      int          ra [NREAD];
      logic [31:0] exp_d;
      bit          exp_h;
      bit          wr_hit;
      bit          acc;
      bit          rel;
      ra[0] = a0;
      ra[1] = a1;
      rst_in      = rst;
      wr_en_in    = we;
      wr_addr_in  = AW'(wa);
      wr_data_in  = wd;
      rsv_en_in   = re;
      rsv_addr_in = AW'(rsa);
      ra_in       = {AW'(a1), AW'(a0)};
      #4;
      for (int p = 0; p < NREAD; p++) begin
         wr_hit = we && (wa == ra[p]);
         if (rst || ra[p] == 0) begin
            exp_d = '0;
            exp_h = 1'b0;
         end else begin
            exp_d = (BYP && wr_hit) ? wd : m_reg[ra[p]];
            exp_h = (m_cnt[ra[p]] != 0) && !(BYP && wr_hit && m_cnt[ra[p]] == 1);
         end
         check($sformatf("rdata%0d x%0d", p, ra[p]), 64'(rdata_out[p*XLEN +: XLEN]), 64'(exp_d));
         check($sformatf("hazard%0d x%0d", p, ra[p]), 64'(hazard_out[p]), 64'(exp_h));
      end
      check($sformatf("rsv_ready x%0d", rsa), 64'(rsv_ready_out),
            64'(rst || rsa == 0 || m_cnt[rsa] < MAXC));
      check("err", 64'(err_out), 64'(m_err));
      @(posedge clk_in);
      if (rst) begin
         model_reset();
      end else begin
         acc = re && rsa != 0 && m_cnt[rsa] < MAXC;
         rel = we && wa != 0;
         if (rel) begin
            m_reg[wa] = wd;
            if (m_cnt[wa] == 0) m_err = 1'b1;
         end
         if (!(acc && rel && wa == rsa)) begin
            if (acc) m_cnt[rsa] = m_cnt[rsa] + 1;
            if (rel && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
         end
      end
      #1;
   endtask

   initial begin
      int          wa;
      int          rsa;
      bit          we;
      bit          re;
      bit          rst;
      logic [31:0] wd;

      rst_in      = 1'b1;
      wr_en_in    = 1'b1;
      wr_addr_in  = AW'(5);
      wr_data_in  = 32'hCAFE_F00D;
      rsv_en_in   = 1'b0;
      rsv_addr_in = '0;
      ra_in       = '0;
      @(posedge clk_in);
      #1;
      model_reset();

      // Reset discards a concurrent write
      cyc(0, 0, 0, 0, 0, 5, 5, 0);
      cyc(0, 1, 5, 32'hAAAA_5555, 0, 0, 5, 1);
      cyc(1, 1, 5, 32'hBBBB_6666, 1, 5, 5, 5);
      cyc(0, 0, 0, 0, 0, 5, 5, 6);

      // x0 immunity
      cyc(0, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Reserve / writeback hazard on x3
      cyc(0, 0, 0, 0, 1, 3, 3, 0);
      cyc(0, 0, 0, 0, 0, 3, 3, 3);
      cyc(0, 1, 3, 32'h1234_5678, 0, 0, 3, 3);
      cyc(0, 0, 0, 0, 0, 0, 3, 3);

      // Saturation on x7
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 7, 7, 0);
      cyc(0, 0, 0, 0, 0, 7, 7, 7);
      for (int k = 0; k < 3; k++) cyc(0, 1, 7, 32'h7000 + k, 0, 7, 7, 7);
      cyc(0, 0, 0, 0, 0, 7, 7, 7);

      // Simultaneous reserve and release on x9
      cyc(0, 0, 0, 0, 1, 9, 9, 0);
      cyc(0, 1, 9, 32'h9999_0001, 1, 9, 9, 9);
      cyc(0, 0, 0, 0, 0, 9, 9, 9);

      // Underflow on x4: sticky error until reset
      cyc(0, 1, 4, 32'h4444_4444, 0, 0, 4, 0);
      cyc(0, 0, 0, 0, 0, 0, 4, 4);
      cyc(0, 0, 0, 0, 0, 0, 4, 4);
      cyc(1, 0, 0, 0, 0, 0, 4, 4);
      cyc(0, 0, 0, 0, 0, 0, 4, 4);

      // Randomized traffic over a narrow address window to force collisions
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         we  = ($urandom_range(0, 1) == 1);
         re  = ($urandom_range(0, 9) < 6);
         wa  = $urandom_range(0, 11);
         rsa = $urandom_range(0, 11);
         wd  = $urandom;
         if (we && re && wa == rsa && m_cnt[wa] == 0) re = 1'b0;
         cyc(rst, we, wa, wd, re, rsa, $urandom_range(0, 11), $urandom_range(0, 11));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
